// File: rtl/serial_detect_arbiter_if.sv
// Bundle between the serial bit sources, the frame arbiter and the shared pattern detector.
// master: the arbiter side; slave: the requesters/detector environment.
interface serial_detect_arbiter_if #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned ID_W      = $clog2(N_REQ),
  parameter int unsigned HIT_W     = $clog2(FRAME_LEN + 1)
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] x_in;
  logic [N_REQ-1:0] gnt;
  logic             det_clr;
  logic             x_out;
  logic             x_valid;
  logic             y_in;
  logic             done;
  logic [ID_W-1:0]  done_id;
  logic [HIT_W-1:0] hit_count;
  logic             aborted;

  modport master (
    input  req, x_in, y_in,
    output gnt, det_clr, x_out, x_valid, done, done_id, hit_count, aborted
  );

  modport slave (
    output req, x_in, y_in,
    input  gnt, det_clr, x_out, x_valid, done, done_id, hit_count, aborted
  );
endinterface

// File: rtl/serial_detect_arbiter.sv
// Round-robin frame arbiter sharing one serial Mealy detector among N_REQ bit sources;
// streams FRAME_LEN bits from the winner and reports the detector hit count per frame.
module serial_detect_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned ID_W      = $clog2(N_REQ),
  parameter int unsigned HIT_W     = $clog2(FRAME_LEN + 1)
) (
  input logic                   clk,
  input logic                   rst,
  serial_detect_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StClear, StStream, StDone} state_e;

  state_e           state_q;
  logic [ID_W-1:0]  winner_q;
  logic [ID_W-1:0]  last_q;
  logic [HIT_W-1:0] bit_cnt_q;
  logic [HIT_W-1:0] hit_cnt_q;
  logic [N_REQ-1:0] gnt_q;
  logic             det_clr_q;
  logic             done_q;
  logic [ID_W-1:0]  done_id_q;
  logic [HIT_W-1:0] hit_count_q;
  logic             aborted_q;

  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  cand;
  logic             pick_found;
  logic             win_req;
  logic             stream_valid;
  logic             hit_inc;
  logic             last_bit;

  // Search starts one past the previous winner so every requester gets its turn.
  always_comb begin
    pick       = '0;
    cand       = '0;
    pick_found = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((32'(last_q) + i) % N_REQ);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  assign win_req      = bus.req[winner_q];
  assign stream_valid = (state_q == StStream) && win_req;
  assign hit_inc      = stream_valid && bus.y_in;
  assign last_bit     = (bit_cnt_q == HIT_W'(FRAME_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      winner_q    <= '0;
      last_q      <= ID_W'(N_REQ - 1);
      bit_cnt_q   <= '0;
      hit_cnt_q   <= '0;
      gnt_q       <= '0;
      det_clr_q   <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      hit_count_q <= '0;
      aborted_q   <= 1'b0;
    end else begin
      det_clr_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            winner_q  <= pick;
            gnt_q     <= N_REQ'(1) << pick;
            det_clr_q <= 1'b1;
            bit_cnt_q <= '0;
            hit_cnt_q <= '0;
            state_q   <= StClear;
          end
        end
        StClear: begin
          state_q <= StStream;
        end
        StStream: begin
          if (!win_req) begin
            // Requester withdrew: report the partial frame without counting this cycle.
            gnt_q       <= '0;
            done_q      <= 1'b1;
            done_id_q   <= winner_q;
            hit_count_q <= hit_cnt_q;
            aborted_q   <= 1'b1;
            state_q     <= StDone;
          end else begin
            bit_cnt_q <= bit_cnt_q + HIT_W'(1);
            hit_cnt_q <= hit_cnt_q + HIT_W'(hit_inc);
            if (last_bit) begin
              gnt_q       <= '0;
              done_q      <= 1'b1;
              done_id_q   <= winner_q;
              hit_count_q <= hit_cnt_q + HIT_W'(hit_inc);
              aborted_q   <= 1'b0;
              state_q     <= StDone;
            end
          end
        end
        StDone: begin
          last_q  <= winner_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.det_clr   = det_clr_q;
  assign bus.x_valid   = stream_valid;
  assign bus.x_out     = stream_valid & bus.x_in[winner_q];
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign bus.hit_count = hit_count_q;
  assign bus.aborted   = aborted_q;

endmodule

// File: tb/tb_serial_detect_arbiter.sv
// Bench for serial_detect_arbiter: table of frames, hand-written reset sequences and random
// frames checked against a frame-level round-robin / adjacent-ones reference model.
module tb_serial_detect_arbiter;
  localparam int unsigned N_REQ     = 4;
  localparam int unsigned FRAME_LEN = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prev_bit = 1'b0;

  serial_detect_arbiter_if #(.N_REQ(N_REQ), .FRAME_LEN(FRAME_LEN)) bus ();

  serial_detect_arbiter #(.N_REQ(N_REQ), .FRAME_LEN(FRAME_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared detector: y = previous frame bit AND current bit, history cleared by det_clr.
  always_ff @(posedge clk) begin
    if (bus.det_clr) prev_bit <= 1'b0;
    else if (bus.x_valid) prev_bit <= bus.x_out;
  end
  assign bus.y_in = bus.x_valid & bus.x_out & prev_bit;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int last_m = 3;
  int prev_id = 0;
  int prev_hits = 0;
  logic prev_ab = 1'b0;

  typedef struct {
    logic [3:0] rq;
    logic [7:0] bits;
    int         drop;
    logic [3:0] late;
    int         eid;
    int         ehits;
    logic       eab;
    int         gap;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    else passed++;
  endtask

  task automatic tick(input logic [3:0] r, input logic [3:0] x, input logic rs);
    @(posedge clk);
    #1;
    bus.req  = r;
    bus.x_in = x;
    rst      = rs;
    cyc++;
    @(negedge clk);
  endtask

  task automatic chk_hold();
    chk("hold_id", 32'(bus.done_id), 32'(prev_id));
    chk("hold_hits", 32'(bus.hit_count), 32'(prev_hits));
    chk("hold_ab", 32'(bus.aborted), 32'(prev_ab));
  endtask

  task automatic frame(input logic [3:0] rq, input logic [7:0] bits, input int drop,
                       input logic [3:0] late, input int eid, input int ehits, input logic eab,
                       input int gap);
    logic [1:0] w;
    logic [3:0] r;
    logic [3:0] x;
    logic       ev;
    w = 2'(eid);
    r = rq;
    tick(rq, 4'($urandom), 1'b0);
    chk("idle_gnt", 32'(bus.gnt), 0);
    chk("idle_done", 32'(bus.done), 0);
    chk_hold();
    tick(rq, 4'($urandom), 1'b0);
    chk("clr_gnt", 32'(bus.gnt), 32'(1) << eid);
    chk("clr_det", 32'(bus.det_clr), 1);
    chk("clr_xv", 32'(bus.x_valid), 0);
    for (int k = 0; k < int'(FRAME_LEN); k++) begin
      r    = rq | late;
      r[w] = (drop < 0) || (k < drop);
      x    = 4'($urandom);
      x[w] = bits[3'(k)];
      tick(r, x, 1'b0);
      ev = (k != drop);
      chk("strm_gnt", 32'(bus.gnt), 32'(1) << eid);
      chk("strm_xv", 32'(bus.x_valid), 32'(ev));
      chk("strm_xout", 32'(bus.x_out), 32'(ev & bits[3'(k)]));
      chk("strm_done", 32'(bus.done), 0);
      if (k == drop) break;
    end
    tick(r, 4'($urandom), 1'b0);
    chk("done_pulse", 32'(bus.done), 1);
    chk("done_id", 32'(bus.done_id), 32'(eid));
    chk("done_hits", 32'(bus.hit_count), 32'(ehits));
    chk("done_ab", 32'(bus.aborted), 32'(eab));
    chk("done_gnt", 32'(bus.gnt), 0);
    if (gap != 0) chk("done_gap", 32'(cyc - last_done_cyc), 32'(gap));
    last_done_cyc = cyc;
    last_m    = eid;
    prev_id   = eid;
    prev_hits = ehits;
    prev_ab   = eab;
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] rq);
    for (int i = 1; i <= 4; i++) if (rq[2'((last + i) % 4)]) return (last + i) % 4;
    return -1;
  endfunction

  function automatic int pair_hits(input logic [7:0] bits, input int n);
    int h = 0;
    for (int i = 1; i < n; i++) if (bits[3'(i)] && bits[3'(i - 1)]) h++;
    return h;
  endfunction

  task automatic reset_model();
    last_m    = 3;
    prev_id   = 0;
    prev_hits = 0;
    prev_ab   = 1'b0;
  endtask

  initial begin
    logic [3:0] rq;
    logic [7:0] bits;
    int drop;
    int w;
    int n;

    tbl[0]  = '{4'b0001, 8'b0111_0110, -1, 4'b0000, 0, 3, 1'b0, 0};
    tbl[1]  = '{4'b1111, 8'hFF,        -1, 4'b0000, 1, 7, 1'b0, 11};
    tbl[2]  = '{4'b1111, 8'h00,        -1, 4'b0000, 2, 0, 1'b0, 11};
    tbl[3]  = '{4'b1111, 8'b1010_1010, -1, 4'b0000, 3, 0, 1'b0, 11};
    tbl[4]  = '{4'b1111, 8'hFF,         3, 4'b0000, 0, 2, 1'b1, 0};
    tbl[5]  = '{4'b1010, 8'b1100_0011, -1, 4'b0000, 1, 2, 1'b0, 0};
    tbl[6]  = '{4'b1010, 8'b0001_1100, -1, 4'b0000, 3, 2, 1'b0, 0};
    tbl[7]  = '{4'b1010, 8'hFF,         0, 4'b0000, 1, 0, 1'b1, 0};
    tbl[8]  = '{4'b0100, 8'hFF,         7, 4'b0000, 2, 6, 1'b1, 0};
    tbl[9]  = '{4'b0001, 8'b0000_0011, -1, 4'b0100, 0, 1, 1'b0, 0};
    tbl[10] = '{4'b0101, 8'b1000_0001, -1, 4'b0000, 2, 0, 1'b0, 0};

    bus.req  = '0;
    bus.x_in = '0;
    tick(4'b0000, 4'b0000, 1'b1);
    tick(4'b0000, 4'b0000, 1'b0);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_det", 32'(bus.det_clr), 0);
    chk("rst_xv", 32'(bus.x_valid), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk_hold();

    foreach (tbl[i])
      frame(tbl[i].rq, tbl[i].bits, tbl[i].drop, tbl[i].late, tbl[i].eid, tbl[i].ehits,
            tbl[i].eab, tbl[i].gap);

    for (int t = 0; t < 40; t++) begin
      rq   = 4'($urandom_range(1, 15));
      bits = 8'($urandom);
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      w    = rr_pick(last_m, rq);
      n    = (drop < 0) ? int'(FRAME_LEN) : drop;
      frame(rq, bits, drop, 4'($urandom), w, pair_hits(bits, n), drop >= 0, 0);
    end

    // Reset during the 5th streamed bit: frame vanishes without a done pulse.
    tick(4'b0001, 4'hF, 1'b0);
    tick(4'b0001, 4'hF, 1'b0);
    for (int k = 0; k < 4; k++) tick(4'b0001, 4'hF, 1'b0);
    tick(4'b0001, 4'hF, 1'b1);
    tick(4'b0000, 4'h0, 1'b0);
    reset_model();
    chk("mid_rst_gnt", 32'(bus.gnt), 0);
    chk("mid_rst_xv", 32'(bus.x_valid), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_hits", 32'(bus.hit_count), 0);
    frame(4'b0010, 8'b0000_0111, -1, 4'b0000, 1, 2, 1'b0, 0);

    tick(4'b0000, 4'h0, 1'b1);
    reset_model();
    frame(4'b1010, 8'hFF, -1, 4'b0000, 1, 7, 1'b0, 0);
    frame(4'b1010, 8'h0F, -1, 4'b0000, 3, 3, 1'b0, 11);
    frame(4'b1010, 8'h00, -1, 4'b0000, 1, 0, 1'b0, 11);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Grant must never show more than one requester.
  always @(negedge clk) begin
    if (!$onehot0(bus.gnt)) begin
      checks++;
      $display("FAIL gnt_onehot at cycle %0d: got %0h required zero or one-hot", cyc, bus.gnt);
    end
  end

endmodule
